// File: rtl/reg_spill_fill.sv
// rtl/reg_spill_fill.sv - register file context spill/fill engine (optional XOR checksum via RSF_CHECKSUM_EN)
`timescale 1ns/1ps
module reg_spill_fill #(
  parameter int pw = 4,
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_mode,
  input  logic [AW-1:0] i_base_addr,
  output logic          o_busy,
  output logic          o_done,
  output logic [pw:0]   o_rf_addr,
  output logic          o_rf_mov,
  output logic          o_rf_wr_en,
  output logic [DW-1:0] o_rf_wr_data,
  input  logic [DW-1:0] i_rf_rd_data,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_wr_en,
  output logic [DW-1:0] o_mem_wr_data,
  input  logic [DW-1:0] i_mem_rd_data,
  output logic [DW-1:0] o_checksum
);

  localparam int N = 2 ** pw;
  localparam logic [pw:0] IDX_LAST = (pw+1)'(N - 1);
  localparam logic [pw:0] IDX_FILL_END = (pw+1)'(N);
  localparam logic [pw:0] IDX_ONE = (pw+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_SPILL, S_FILL, S_DONE} state_t;

  state_t        r_state;
  logic [pw:0]   r_idx;
  logic          r_busy;
  logic          r_done;
  logic [pw:0]   r_rf_addr;
  logic          r_rf_wr_en;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_wr_en;
  logic          w_accept;

  assign w_accept = (r_state == S_IDLE) && i_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_wr_en  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wr_en <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_rf_addr   <= '0;
            r_mem_addr  <= i_base_addr;
            r_mem_wr_en <= ~i_mode;
            r_state     <= i_mode ? S_FILL : S_SPILL;
          end
        end
        S_SPILL: begin
          if (r_idx == IDX_LAST) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_idx      <= r_idx + IDX_ONE;
            r_rf_addr  <= r_idx + IDX_ONE;
            r_mem_addr <= r_mem_addr + AW'(1);
          end
        end
        S_FILL: begin
          // Register writes trail memory reads by one cycle (synchronous memory).
          if (r_idx == IDX_FILL_END) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_rf_wr_en <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_idx      <= r_idx + IDX_ONE;
            r_rf_wr_en <= 1'b1;
            r_rf_addr  <= r_idx;
            if (r_idx != IDX_LAST) r_mem_addr <= r_mem_addr + AW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RSF_CHECKSUM_EN
  logic [DW-1:0] r_checksum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (r_mem_wr_en) begin
      r_checksum <= r_checksum ^ i_rf_rd_data;
    end else if (r_rf_wr_en) begin
      r_checksum <= r_checksum ^ i_mem_rd_data;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_rf_addr     = r_rf_addr;
  assign o_rf_mov      = r_busy;
  assign o_rf_wr_en    = r_rf_wr_en;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wr_en   = r_mem_wr_en;
  // Data pass-throughs are gated so they read as zero whenever the matching enable is low.
  assign o_mem_wr_data = r_mem_wr_en ? i_rf_rd_data : '0;
  assign o_rf_wr_data  = r_rf_wr_en ? i_mem_rd_data : '0;

endmodule

// File: tb/tb_reg_spill_fill.sv
// tb/tb_reg_spill_fill.sv - self-checking bench for reg_spill_fill with register file and memory models
`timescale 1ns/1ps
module tb_reg_spill_fill;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic       busy, done, rf_mov, rf_wr_en, mem_wr_en;
  logic [4:0] rf_addr;
  logic [7:0] rf_wr_data, rf_rd_data, mem_addr, mem_wr_data, mem_rd_data, checksum;

  logic [7:0] rf [0:31];
  logic [7:0] mem [0:255];
  logic [7:0] rf_init [0:31];
  logic [7:0] mem_init [0:255];
  logic [7:0] exp_rf [0:31];
  logic [7:0] exp_mem [0:255];
  logic       load = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_spill_fill #(.pw(4), .DW(8), .AW(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_base_addr(base_addr),
    .o_busy(busy), .o_done(done), .o_rf_addr(rf_addr), .o_rf_mov(rf_mov),
    .o_rf_wr_en(rf_wr_en), .o_rf_wr_data(rf_wr_data), .i_rf_rd_data(rf_rd_data),
    .o_mem_addr(mem_addr), .o_mem_wr_en(mem_wr_en), .o_mem_wr_data(mem_wr_data),
    .i_mem_rd_data(mem_rd_data), .o_checksum(checksum)
  );

  assign rf_rd_data = rf[rf_addr];

  always @(posedge clk) begin
    if (load) begin
      rf  <= rf_init;
      mem <= mem_init;
    end else begin
      if (rf_wr_en) rf[rf_addr] <= rf_wr_data;
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load();
    @(negedge clk);
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic check_arrays(input string tag);
    int bad_rf = 0;
    int bad_mem = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== exp_rf[i]) bad_rf++;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad_mem++;
    chk({tag, "_rf_mismatches"}, bad_rf, 0);
    chk({tag, "_mem_mismatches"}, bad_mem, 0);
  endtask

  task automatic run_op(input string tag, input logic md, input logic [7:0] base, input bit hold);
    int cyc = 0;
    int busy_cnt = 0;
    int wr_cnt = 0;
    int first_rf = 0;
    int extra = 0;
    bit got_done = 0;
    bit bad_en = 0;
    bit oor = 0;
    bit mov_bad = 0;
    logic [4:0] fa = '0;
    logic [7:0] fd = '0;
    logic [7:0] diff;
    logic [7:0] exp_ck = '0;
    logic [7:0] ck_done;
    for (int i = 0; i < 32; i++) exp_rf[i] = rf[i];
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < 16; i++) begin
      if (!md) begin
        exp_mem[8'(base + i)] = rf[i];
        exp_ck ^= rf[i];
      end else begin
        exp_rf[i] = mem[8'(base + i)];
        exp_ck ^= mem[8'(base + i)];
      end
    end
`ifndef RSF_CHECKSUM_EN
    exp_ck = 8'h00;
`endif
    @(negedge clk);
    start = 1'b1; mode = md; base_addr = base;
    @(posedge clk);
    if (!hold) #1 start = 1'b0;
    while (!got_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (rf_mov !== busy) mov_bad = 1;
      if (!md && rf_wr_en) bad_en = 1;
      if (md && mem_wr_en) bad_en = 1;
      if (mem_wr_en) begin
        wr_cnt++;
        diff = mem_addr - base;
        if (diff >= 8'd16) oor = 1;
      end
      if (rf_wr_en && first_rf == 0) begin
        first_rf = cyc; fa = rf_addr; fd = rf_wr_data;
      end
      if (done) got_done = 1;
    end
    ck_done = checksum;
    chk({tag, "_latency"}, cyc, md ? 18 : 17);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_busy_cycles"}, busy_cnt, md ? 17 : 16);
    chk({tag, "_wrong_enable"}, bad_en, 0);
    chk({tag, "_rf_mov"}, mov_bad, 0);
    chk({tag, "_mem_writes"}, wr_cnt, md ? 0 : 16);
    chk({tag, "_addr_range"}, oor, 0);
    chk({tag, "_checksum_done"}, ck_done, exp_ck);
    if (md) begin
      chk({tag, "_first_wr_cycle"}, first_rf, 2);
      chk({tag, "_first_wr_addr"}, fa, 0);
      chk({tag, "_first_wr_data"}, fd, exp_rf[0]);
    end
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_checksum_hold"}, checksum, exp_ck);
    if (hold) begin
      chk({tag, "_idle_gap"}, busy, 0);
      @(negedge clk);
      chk({tag, "_restart_after_gap"}, busy, 1);
      start = 1'b0;
      while (!done && extra < 40) begin
        @(negedge clk);
        extra++;
      end
      chk({tag, "_second_done"}, done, 1);
      @(negedge clk);
    end
    check_arrays(tag);
  endtask

  initial begin
    int nwr;
    int guard;
    logic [7:0] b;
    for (int i = 0; i < 32; i++) rf_init[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem_init[i] = 8'(i ^ 8'h5A);
    do_load();
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rf_mov", rf_mov, 0);
    chk("reset_rf_wr_en", rf_wr_en, 0);
    chk("reset_mem_wr_en", mem_wr_en, 0);
    chk("reset_rf_addr", rf_addr, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_checksum", checksum, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) rf_init[i] = 8'(8'h10 + i);
    do_load();
    run_op("spill_40", 1'b0, 8'h40, 1'b0);

    for (int i = 0; i < 16; i++) mem_init[8'h80 + i] = 8'(8'hA0 + i);
    for (int i = 0; i < 32; i++) rf_init[i] = 8'h00;
    do_load();
    run_op("fill_80", 1'b1, 8'h80, 1'b0);

    for (int i = 0; i < 16; i++) rf_init[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem_init[i] = 8'hEE;
    do_load();
    run_op("spill_wrap", 1'b0, 8'hF8, 1'b0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 32; i++) rf_init[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem_init[i] = 8'($urandom);
      do_load();
      run_op($sformatf("rand%0d", t), 1'($urandom), 8'($urandom), 1'b0);
    end

    run_op("start_hold", 1'b0, 8'h20, 1'b1);

    for (int i = 0; i < 32; i++) rf_init[i] = 8'(8'h30 + i);
    for (int i = 0; i < 256; i++) mem_init[i] = 8'($urandom);
    do_load();
    b = 8'($urandom);
    for (int i = 0; i < 32; i++) exp_rf[i] = rf[i];
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < 5; i++) exp_rf[i] = mem[8'(b + i)];
    @(negedge clk);
    start = 1'b1; mode = 1'b1; base_addr = b;
    @(posedge clk);
    #1 start = 1'b0;
    nwr = 0; guard = 0;
    while (nwr < 5 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (rf_wr_en) nwr++;
    end
    chk("rst_mid_fill_writes_seen", nwr, 5);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rf_mov", rf_mov, 0);
    chk("rst_mid_rf_wr_en", rf_wr_en, 0);
    chk("rst_mid_rf_addr", rf_addr, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_rf_wr_data", rf_wr_data, 0);
    chk("rst_mid_mem_wr_data", mem_wr_data, 0);
    chk("rst_mid_checksum", checksum, 0);
    @(negedge clk);
    check_arrays("rst_mid_fill");
    rst_n = 1'b1;
    run_op("after_reset", 1'b0, 8'h10, 1'b0);

    for (int i = 0; i < 32; i++) rf_init[i] = (i < 8) ? 8'(1 << i) : 8'h00;
    do_load();
    run_op("ck_pattern", 1'b0, 8'h60, 1'b0);
`ifdef RSF_CHECKSUM_EN
    chk("ck_pattern_value", checksum, 8'hFF);
`else
    chk("ck_pattern_value", checksum, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_spill_fill.md
Name: reg_spill_fill

Overview:
- Context save/restore engine that sits on the far side of the register file's read and write ports.
- Spill: reads all 2**pw registers in order and writes them to data memory starting at a base address.
- Fill: reads 2**pw bytes from data memory and writes them back into the registers.
- Core stalls on busy; while busy, this block owns the register-file address, write-enable, move-select and write-data inputs.

Parameters:
- pw, 4, register pointer width; 2**pw registers transferred; rf_addr is pw+1 bits wide to match the register-file address ports.
- DW, 8, data width of registers and memory.
- AW, 8, data memory address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = spill (regs to mem), 1 = fill (mem to regs); sampled with start.
- base_addr  in  AW  first memory address; sampled with start.
- busy  out  1  transfer in progress; core must stall.
- done  out  1  one-cycle pulse after the last transfer.
- rf_addr  out  pw+1  register index; drives both register-file address ports.
- rf_mov  out  1  high while busy, so the register file uses rf_addr and not register 0.
- rf_wr_en  out  1  register write enable (fill only).
- rf_wr_data  out  DW  register write data.
- rf_rd_data  in  DW  combinational register read data at rf_addr.
- mem_addr  out  AW  memory address.
- mem_wr_en  out  1  memory write enable (spill only).
- mem_wr_data  out  DW  memory write data.
- mem_rd_data  in  DW  synchronous memory read data; valid the cycle after the address is presented.
- checksum  out  DW  XOR of transferred bytes (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - State goes to IDLE; index clears to 0.
  - busy, done, rf_mov, rf_wr_en, mem_wr_en, rf_addr, mem_addr, rf_wr_data, mem_wr_data and checksum all go to 0.
  - Already-transferred data is not rolled back.
- States: IDLE, SPILL, FILL, DONE.
- IDLE:
  - start=1 at a posedge latches mode and base_addr, clears the index and enters SPILL (mode=0) or FILL (mode=1).
  - start while not in IDLE is ignored and not queued.
- SPILL, cycles i = 0 .. 2**pw-1:
  - rf_addr = i; mem_addr = base_addr + i, truncated to AW bits (wraps 0xFF to 0x00).
  - mem_wr_en = 1; mem_wr_data = rf_rd_data, a combinational pass-through.
  - After i = 2**pw-1, go to DONE.
  - Total: 16 write cycles for pw=4.
- FILL: two-stage pipeline, 2**pw+1 cycles.
  - Cycle k = 0 .. 2**pw-1: mem_addr = base_addr + k (wrapping).
  - Cycle k+1: rf_wr_en = 1, rf_addr = k, rf_wr_data = mem_rd_data.
  - Cycle 0 has rf_wr_en = 0. Cycle 2**pw has no new memory address; mem_addr holds its last value.
  - Then go to DONE.
- DONE: busy = 0, done = 1 for exactly one cycle, all enables 0; then IDLE.
  - A start in the DONE cycle is ignored.
  - A start in the cycle after DONE is accepted: back-to-back operations with one idle gap.
- busy is high from the cycle after start is accepted through the last SPILL or FILL cycle inclusive.
- rf_mov = busy.
- mem_wr_en is never high in FILL; rf_wr_en is never high in SPILL.
- All control outputs are registered, except mem_wr_data and rf_wr_data, which are pass-throughs of the read data.
- Latency start to done:
  - Spill: 2**pw+1 cycles (17 for pw=4).
  - Fill: 2**pw+2 cycles (18 for pw=4).

Optional Feature:
- Macro: RSF_CHECKSUM_EN.
- Defined:
  - checksum clears to 0 when start is accepted.
  - Each transferred byte is XORed in: spill on every mem_wr_en cycle, fill on every rf_wr_en cycle.
  - Value is final and stable from the done cycle until the next accepted start.
- Undefined: checksum is tied to 0 and no accumulator logic is built.

Test Plan:
- Spill: regs r0..r15 = 0x10..0x1F, base_addr = 0x40, start mode=0 -> busy for 16 cycles; mem[0x40..0x4F] = 0x10..0x1F; done pulses at cycle 17; rf_wr_en never high.
- Fill: mem[0x80..0x8F] = 0xA0..0xAF, start mode=1 -> first rf_wr_en at cycle 2 with rf_addr=0 and data 0xA0; regs = 0xA0..0xAF; done at cycle 18.
- Wrap: spill with base_addr = 0xF8 -> writes to 0xF8..0xFF then 0x00..0x07; no write outside that range.
- Start ignored: assert start continuously during a spill and in the DONE cycle -> exactly one transfer; next transfer begins only after the idle gap.
- Reset mid-fill: drop rst_n after 5 register writes -> all outputs 0 immediately; regs r0..r4 updated, r5..r15 unchanged; next start runs normally.
- RSF_CHECKSUM_EN: spill with r0..r15 = 0x01,0x02,0x04,...,0x80,0x00 x8 -> checksum = 0xFF at done; with the macro undefined -> checksum = 0x00.
